// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// muldiv_unit_pkg
//   Decoded-op and FSM-state types for the RV64M multiply/divide unit.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        ALU   = 4'd1,
        MUL   = 4'd2,
        MULW  = 4'd3,
        DIV   = 4'd4,
        DIVU  = 4'd5,
        REM   = 4'd6,
        REMU  = 4'd7,
        DIVW  = 4'd8,
        DIVUW = 4'd9,
        REMW  = 4'd10,
        REMUW = 4'd11
    } decode_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } md_state_t;

    function automatic logic is_mul(input decode_op_t op);
        return (op == MUL) || (op == MULW);
    endfunction

    function automatic logic is_div(input decode_op_t op);
        return (op == DIV)  || (op == DIVU)  || (op == REM)  || (op == REMU) ||
               (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_word(input decode_op_t op);
        return (op == MULW) || (op == DIVW) || (op == DIVUW) ||
               (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_rem(input decode_op_t op);
        return (op == REM) || (op == REMU) || (op == REMW) || (op == REMUW);
    endfunction

    function automatic logic is_signed_div(input decode_op_t op);
        return (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// muldiv_unit_if
//   Execute-stage interface between the pipeline and the multiply/divide unit.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
);
    decode_op_t       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             hold;
    logic             flush;
    logic             done;
    logic [XLEN-1:0]  result;

    modport master (
        output op, a, b, hold, flush,
        input  done, result
    );

    modport slave (
        input  op, a, b, hold, flush,
        output done, result
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit_div.sv
// ============================================================================
// div_iter
//   Unsigned restoring divider, one quotient bit per cycle; start performs step 0.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module div_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [XLEN-1:0]  dividend,
    input  wire logic [XLEN-1:0]  divisor,
    input  wire logic [CNT_W-1:0] steps,
    output logic                  busy,
    output logic [XLEN-1:0]       q,
    output logic [XLEN-1:0]       r
);
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvs;
    logic [CNT_W-1:0] r_left;

    logic [XLEN-1:0]  w_rem_in;
    logic [XLEN-1:0]  w_quo_in;
    logic [XLEN-1:0]  w_dvs_in;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_rem_nx;
    logic [XLEN-1:0]  w_quo_nx;

    // Short (W) divides pre-align the dividend so its MSB enters the remainder first.
    always_comb begin
        w_rem_in = start ? '0 : r_rem;
        w_quo_in = start ? (dividend << (CNT_W'(XLEN) - steps)) : r_quo;
        w_dvs_in = start ? divisor : r_dvs;
        w_shift  = {w_rem_in, w_quo_in[XLEN-1]};
        w_diff   = w_shift - {1'b0, w_dvs_in};
        if (w_diff[XLEN]) begin
            w_rem_nx = w_shift[XLEN-1:0];
            w_quo_nx = {w_quo_in[XLEN-2:0], 1'b0};
        end else begin
            w_rem_nx = w_diff[XLEN-1:0];
            w_quo_nx = {w_quo_in[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_left <= '0;
        end else if (abort) begin
            r_left <= '0;
        end else if (start) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_dvs  <= divisor;
            r_left <= steps - CNT_W'(1);
        end else if (busy) begin
            r_rem  <= w_rem_nx;
            r_quo  <= w_quo_nx;
            r_left <= r_left - CNT_W'(1);
        end
    end

    assign busy = (r_left != '0);
    assign q    = r_quo;
    assign r    = r_rem;
endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
//   RV64M execute unit: single-cycle MUL/MULW, iterative DIV/REM with stall 'done'.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int DIV_STEPS = 64
) (
    input  wire logic     clk,
    input  wire logic     reset,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_STEPS + 1);
    localparam int HALF  = XLEN / 2;

    function automatic logic [XLEN-1:0] ext_half(input logic [HALF-1:0] v, input logic sgn);
        return {{HALF{sgn & v[HALF-1]}}, v};
    endfunction

    md_state_t        r_state;
    md_state_t        w_state_nx;
    decode_op_t       r_op;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_result;

    logic             w_word_in;
    logic             w_sgn_in;
    logic [XLEN-1:0]  w_opa;
    logic [XLEN-1:0]  w_opb;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic [CNT_W-1:0] w_steps;

    logic             w_done;
    logic             w_issue;
    logic             w_load;
    logic             w_div_busy;
    logic [XLEN-1:0]  w_div_q;
    logic [XLEN-1:0]  w_div_r;
    logic [XLEN-1:0]  w_prod;
    logic [XLEN-1:0]  w_min;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_q_fix;
    logic [XLEN-1:0]  w_r_fix;
    logic [XLEN-1:0]  w_raw;
    logic [XLEN-1:0]  w_res_nx;

    // Operand preparation from the live bus, consumed only on the issue cycle.
    assign w_word_in = is_word(bus.op);
    assign w_sgn_in  = is_signed_div(bus.op);
    assign w_opa     = w_word_in ? ext_half(bus.a[HALF-1:0], w_sgn_in) : bus.a;
    assign w_opb     = w_word_in ? ext_half(bus.b[HALF-1:0], w_sgn_in) : bus.b;
    assign w_a_neg   = w_sgn_in & w_opa[XLEN-1];
    assign w_b_neg   = w_sgn_in & w_opb[XLEN-1];
    assign w_mag_a   = w_a_neg ? -w_opa : w_opa;
    assign w_mag_b   = w_b_neg ? -w_opb : w_opb;
    assign w_steps   = w_word_in ? CNT_W'(DIV_STEPS / 2) : CNT_W'(DIV_STEPS);

    div_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_issue & is_div(bus.op)),
        .abort    (bus.flush),
        .dividend (w_mag_a),
        .divisor  (w_mag_b),
        .steps    (w_steps),
        .busy     (w_div_busy),
        .q        (w_div_q),
        .r        (w_div_r)
    );

    // Special cases are decided from the latched, already-extended operands.
    assign w_prod    = r_a * r_b;
    assign w_min     = is_word(r_op) ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                                     : {1'b1, {(XLEN - 1){1'b0}}};
    assign w_b_zero  = (r_b == '0);
    assign w_ovf     = is_signed_div(r_op) && (r_a == w_min) && (r_b == '1);
    assign w_special = w_b_zero || w_ovf;
    assign w_q_fix   = r_neg_q ? -w_div_q : w_div_q;
    assign w_r_fix   = r_neg_r ? -w_div_r : w_div_r;

    always_comb begin
        w_raw = w_prod;
        if (r_state == S_DIV) begin
            if (w_b_zero)
                w_raw = is_rem(r_op) ? r_a : '1;
            else if (w_ovf)
                w_raw = is_rem(r_op) ? '0 : r_a;
            else
                w_raw = is_rem(r_op) ? w_r_fix : w_q_fix;
        end
        w_res_nx = is_word(r_op) ? ext_half(w_raw[HALF-1:0], 1'b1) : w_raw;
    end

    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b1;
        w_issue    = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (is_mul(bus.op) || is_div(bus.op)) begin
                    w_done = 1'b0;
                    if (!bus.flush) begin
                        w_issue    = 1'b1;
                        w_state_nx = is_mul(bus.op) ? S_MUL : S_DIV;
                    end
                end
            end
            S_MUL: begin
                w_done     = 1'b0;
                w_load     = 1'b1;
                w_state_nx = S_FIN;
            end
            S_DIV: begin
                w_done = 1'b0;
                if (w_special || !w_div_busy) begin
                    w_load     = 1'b1;
                    w_state_nx = S_FIN;
                end
            end
            S_FIN: begin
                if (!bus.hold)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nx = S_IDLE;
            w_load     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= NOP;
            r_a      <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_issue) begin
                r_op    <= bus.op;
                r_a     <= w_opa;
                r_b     <= w_opb;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
            if (w_load)
                r_result <= w_res_nx;
        end
    end

    assign bus.done   = w_done;
    assign bus.result = r_result;
endmodule

`default_nettype wire
